// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the 32-bit bus CPU. Steps each instruction
//   through fetch (T0..T2) and an opcode-dependent execute phase (T3..T7),
//   and decodes the current step, IR and CON into every datapath control.
//
// Ports
//   clock          in   rising-edge clock
//   clear          in   synchronous active-high reset; also forces all outputs low
//   ir[31:0]       in   IR contents, opcode in ir[31:27]
//   con_ff         in   branch condition, looked at in step T6 of br only
//   stop           in   halt request, honoured on the last step of an instruction
//   *out           out  bus source selects (never more than one high)
//   *_enable       out  register loads
//   IncPC, Read, Write, CON_in              out  PC / memory / CON strobes
//   GRA, GRB, GRC, Rin, Rout, BAout         out  IR register-field controls
//   operation[OPW-1:0]                      out  ALU opcode
//   run            out  1 while executing, 0 when halted or in clear
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_T0    | fetch: PC to MAR, increment PC
// S_T1    | fetch: memory read into MDR
// S_T2    | fetch: MDR to IR; nop/halt finish here
// S_T3-T7 | execute steps, sequence chosen by opcode class
// S_HALT  | stopped, all controls low, left only through clear

module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           stop,
    output logic           PCout,
    output logic           ZLowout,
    output logic           ZHighout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           Cout,
    output logic           InPortout,
    output logic           MAR_enable,
    output logic           MDR_enable,
    output logic           IR_enable,
    output logic           Y_enable,
    output logic           PC_enable,
    output logic           Z_low_enable,
    output logic           Z_high_enable,
    output logic           HI_enable,
    output logic           LO_enable,
    output logic           OutPort_enable,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           CON_in,
    output logic           GRA,
    output logic           GRB,
    output logic           GRC,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic [OPW-1:0] operation,
    output logic           run
);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t state_q, state_d;
    state_t last_step;

    logic [OPW-1:0] op;
    logic c_ld, c_ldi, c_st, c_mem, c_alu3, c_imm, c_muldiv, c_unary;
    logic c_br, c_jal, c_jr, c_in, c_out, c_mflo, c_mfhi, c_halt;

    // Only the opcode field matters to the sequencer; the register fields
    // are decoded by the datapath itself under GRA/GRB/GRC.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[31-OPW:0];

    assign op = ir[31 -: OPW];

    always_comb begin
        c_ld     = (op == OPW'(0));
        c_ldi    = (op == OPW'(1));
        c_st     = (op == OPW'(2));
        c_mem    = c_ld | c_ldi | c_st;
        c_alu3   = (op >= OPW'(3))  && (op <= OPW'(11));
        c_imm    = (op >= OPW'(12)) && (op <= OPW'(14));
        c_muldiv = (op == OPW'(15)) || (op == OPW'(16));
        c_unary  = (op == OPW'(17)) || (op == OPW'(18));
        c_br     = (op == OPW'(19));
        c_jal    = (op == OPW'(20));
        c_jr     = (op == OPW'(21));
        c_in     = (op == OPW'(22));
        c_out    = (op == OPW'(23));
        c_mflo   = (op == OPW'(24));
        c_mfhi   = (op == OPW'(25));
        c_halt   = (op == OPW'(27));
    end

    // Final step of the current instruction; anything unlisted (nop,
    // halt and the spare opcodes) ends with fetch.
    always_comb begin
        last_step = S_T2;
        if (c_jr || c_in || c_out || c_mflo || c_mfhi)
            last_step = S_T3;
        else if (c_unary || c_jal)
            last_step = S_T4;
        else if (c_alu3 || c_imm || c_ldi)
            last_step = S_T5;
        else if (c_muldiv || c_br)
            last_step = S_T6;
        else if (c_ld || c_st)
            last_step = S_T7;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_HALT) begin
            state_d = S_HALT;
        end else if (state_q == last_step) begin
            state_d = (c_halt || stop) ? S_HALT : S_T0;
        end else begin
            case (state_q)
                S_T0:    state_d = S_T1;
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_T4;
                S_T4:    state_d = S_T5;
                S_T5:    state_d = S_T6;
                S_T6:    state_d = S_T7;
                default: state_d = S_T0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear)
            state_q <= S_T0;
        else
            state_q <= state_d;
    end

    always_comb begin
        PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
        MAR_enable = 1'b0; MDR_enable = 1'b0; IR_enable = 1'b0; Y_enable = 1'b0;
        PC_enable = 1'b0; Z_low_enable = 1'b0; Z_high_enable = 1'b0;
        HI_enable = 1'b0; LO_enable = 1'b0; OutPort_enable = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0; CON_in = 1'b0;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        operation = '0;
        run = 1'b0;

        // clear overrides the decode so an abandoned instruction cannot
        // strobe anything during the reset cycle.
        if (!clear && state_q != S_HALT) begin
            run = 1'b1;
            case (state_q)
                S_T0: begin
                    PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1;
                end
                S_T1: begin
                    Read = 1'b1; MDR_enable = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1; IR_enable = 1'b1;
                end
                S_T3: begin
                    if (c_alu3 || c_imm) begin
                        GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                    end else if (c_unary) begin
                        GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = op;
                    end else if (c_mem) begin
                        GRB = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                    end else if (c_muldiv) begin
                        GRA = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                    end else if (c_br) begin
                        GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1;
                    end else if (c_jr) begin
                        GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
                    end else if (c_jal) begin
                        PCout = 1'b1; GRB = 1'b1; Rin = 1'b1;
                    end else if (c_in) begin
                        InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (c_out) begin
                        GRA = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1;
                    end else if (c_mflo) begin
                        LOout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (c_mfhi) begin
                        HIout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end
                end
                S_T4: begin
                    if (c_alu3) begin
                        GRC = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = op;
                    end else if (c_imm) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = op;
                    end else if (c_unary) begin
                        ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (c_mem) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = ALU_ADD;
                    end else if (c_muldiv) begin
                        GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1;
                        Z_high_enable = 1'b1; operation = op;
                    end else if (c_br) begin
                        PCout = 1'b1; Y_enable = 1'b1;
                    end else if (c_jal) begin
                        GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
                    end
                end
                S_T5: begin
                    if (c_alu3 || c_imm || c_ldi) begin
                        ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (c_ld || c_st) begin
                        ZLowout = 1'b1; MAR_enable = 1'b1;
                    end else if (c_muldiv) begin
                        ZLowout = 1'b1; LO_enable = 1'b1;
                    end else if (c_br) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = ALU_ADD;
                    end
                end
                S_T6: begin
                    if (c_ld) begin
                        Read = 1'b1; MDR_enable = 1'b1;
                    end else if (c_st) begin
                        GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1;
                    end else if (c_muldiv) begin
                        ZHighout = 1'b1; HI_enable = 1'b1;
                    end else if (c_br && con_ff) begin
                        ZLowout = 1'b1; PC_enable = 1'b1;
                    end
                end
                S_T7: begin
                    if (c_ld) begin
                        MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (c_st) begin
                        Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    typedef logic [33:0] vec_t;

    // Bit positions of the packed observation vector below.
    localparam vec_t M_BAO  = 34'd1 << 0;
    localparam vec_t M_ROUT = 34'd1 << 1;
    localparam vec_t M_RIN  = 34'd1 << 2;
    localparam vec_t M_GRC  = 34'd1 << 3;
    localparam vec_t M_GRB  = 34'd1 << 4;
    localparam vec_t M_GRA  = 34'd1 << 5;
    localparam vec_t M_CON  = 34'd1 << 6;
    localparam vec_t M_WR   = 34'd1 << 7;
    localparam vec_t M_RD   = 34'd1 << 8;
    localparam vec_t M_INC  = 34'd1 << 9;
    localparam vec_t M_OPE  = 34'd1 << 10;
    localparam vec_t M_LOE  = 34'd1 << 11;
    localparam vec_t M_HIE  = 34'd1 << 12;
    localparam vec_t M_ZHE  = 34'd1 << 13;
    localparam vec_t M_ZLE  = 34'd1 << 14;
    localparam vec_t M_PCE  = 34'd1 << 15;
    localparam vec_t M_YE   = 34'd1 << 16;
    localparam vec_t M_IRE  = 34'd1 << 17;
    localparam vec_t M_MDRE = 34'd1 << 18;
    localparam vec_t M_MARE = 34'd1 << 19;
    localparam vec_t M_INP  = 34'd1 << 20;
    localparam vec_t M_COUT = 34'd1 << 21;
    localparam vec_t M_LOO  = 34'd1 << 22;
    localparam vec_t M_HIO  = 34'd1 << 23;
    localparam vec_t M_MDRO = 34'd1 << 24;
    localparam vec_t M_ZHO  = 34'd1 << 25;
    localparam vec_t M_ZLO  = 34'd1 << 26;
    localparam vec_t M_PCO  = 34'd1 << 27;
    localparam vec_t M_RUN  = 34'd1 << 33;

    typedef struct {
        vec_t  v;
        string tag;
        int    step;
    } exp_t;

    exp_t exp_q[$];
    vec_t mdl[$];
    int   errors = 0;
    int   checks = 0;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;

    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    logic MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable;
    logic Z_low_enable, Z_high_enable, HI_enable, LO_enable, OutPort_enable;
    logic IncPC, Read, Write, CON_in, GRA, GRB, GRC, Rin, Rout, BAout;
    logic [4:0] operation;
    logic run;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .PC_enable(PC_enable), .Z_low_enable(Z_low_enable),
        .Z_high_enable(Z_high_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .OutPort_enable(OutPort_enable), .IncPC(IncPC), .Read(Read), .Write(Write),
        .CON_in(CON_in), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .operation(operation), .run(run)
    );

    vec_t got;
    assign got = {run, operation, PCout, ZLowout, ZHighout, MDRout, HIout, LOout,
                  Cout, InPortout, MAR_enable, MDR_enable, IR_enable, Y_enable,
                  PC_enable, Z_low_enable, Z_high_enable, HI_enable, LO_enable,
                  OutPort_enable, IncPC, Read, Write, CON_in, GRA, GRB, GRC, Rin,
                  Rout, BAout};

    function automatic vec_t opv(input logic [4:0] o);
        return {1'b0, o, 28'd0};
    endfunction

    // Reference: the per-step control sets of each instruction class,
    // written straight from the instruction table.
    task automatic model_steps(input logic [4:0] op, input bit con6);
        int o;
        o = int'(op);
        mdl.delete();
        mdl.push_back(M_RUN | M_PCO | M_MARE | M_INC);
        mdl.push_back(M_RUN | M_RD | M_MDRE);
        mdl.push_back(M_RUN | M_MDRO | M_IRE);
        if (o >= 3 && o <= 11) begin
            mdl.push_back(M_RUN | M_GRB | M_ROUT | M_YE);
            mdl.push_back(M_RUN | M_GRC | M_ROUT | M_ZLE | opv(op));
            mdl.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (o == 17 || o == 18) begin
            mdl.push_back(M_RUN | M_GRB | M_ROUT | M_ZLE | opv(op));
            mdl.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (o >= 12 && o <= 14) begin
            mdl.push_back(M_RUN | M_GRB | M_ROUT | M_YE);
            mdl.push_back(M_RUN | M_COUT | M_ZLE | opv(op));
            mdl.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (o <= 2) begin
            mdl.push_back(M_RUN | M_GRB | M_BAO | M_YE);
            mdl.push_back(M_RUN | M_COUT | M_ZLE | opv(5'b00011));
            if (o == 1) begin
                mdl.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
            end else begin
                mdl.push_back(M_RUN | M_ZLO | M_MARE);
                if (o == 0) begin
                    mdl.push_back(M_RUN | M_RD | M_MDRE);
                    mdl.push_back(M_RUN | M_MDRO | M_GRA | M_RIN);
                end else begin
                    mdl.push_back(M_RUN | M_GRA | M_ROUT | M_MDRE);
                    mdl.push_back(M_RUN | M_WR);
                end
            end
        end else if (o == 15 || o == 16) begin
            mdl.push_back(M_RUN | M_GRA | M_ROUT | M_YE);
            mdl.push_back(M_RUN | M_GRB | M_ROUT | M_ZLE | M_ZHE | opv(op));
            mdl.push_back(M_RUN | M_ZLO | M_LOE);
            mdl.push_back(M_RUN | M_ZHO | M_HIE);
        end else if (o == 19) begin
            mdl.push_back(M_RUN | M_GRA | M_ROUT | M_CON);
            mdl.push_back(M_RUN | M_PCO | M_YE);
            mdl.push_back(M_RUN | M_COUT | M_ZLE | opv(5'b00011));
            mdl.push_back(con6 ? (M_RUN | M_ZLO | M_PCE) : M_RUN);
        end else if (o == 20) begin
            mdl.push_back(M_RUN | M_PCO | M_GRB | M_RIN);
            mdl.push_back(M_RUN | M_GRA | M_ROUT | M_PCE);
        end else if (o == 21) mdl.push_back(M_RUN | M_GRA | M_ROUT | M_PCE);
        else if (o == 22) mdl.push_back(M_RUN | M_INP | M_GRA | M_RIN);
        else if (o == 23) mdl.push_back(M_RUN | M_GRA | M_ROUT | M_OPE);
        else if (o == 24) mdl.push_back(M_RUN | M_LOO | M_GRA | M_RIN);
        else if (o == 25) mdl.push_back(M_RUN | M_HIO | M_GRA | M_RIN);
    endtask

    task automatic push(input vec_t v, input string tag, input int step);
        exp_t e;
        e.v = v; e.tag = tag; e.step = step;
        exp_q.push_back(e);
    endtask

    // Called one time unit after a rising edge, at the start of a T0 cycle.
    // con_mode/stop_mode: 0 = held low, 1 = held high, 2 = random per cycle.
    // clr_at >= 0 aborts the instruction with clear in that cycle.
    task automatic issue(input logic [31:0] ins, input string tag,
                         input int con_mode, input int stop_mode, input int clr_at);
        bit c[8];
        bit s[8];
        int len, n;
        bit halts;
        for (int i = 0; i < 8; i++) begin
            c[i] = (con_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(con_mode);
            s[i] = (stop_mode == 2) ? ($urandom_range(0, 9) == 0) : 1'(stop_mode);
        end
        model_steps(ins[31:27], c[6]);
        len = mdl.size();
        n = (clr_at >= 0 && clr_at < len) ? clr_at : len;
        halts = (clr_at < 0) && (ins[31:27] == 5'b11011 || s[len-1]);
        for (int i = 0; i < n; i++) push(mdl[i], tag, i);
        if (clr_at >= 0) push('0, {tag, "/clear"}, n);
        ir = ins;
        for (int i = 0; i < n; i++) begin
            con_ff = c[i];
            stop = s[i];
            @(posedge clock); #1;
        end
        con_ff = 1'b0;
        stop = 1'b0;
        if (clr_at >= 0) begin
            clear = 1'b1;
            @(posedge clock); #1;
            clear = 1'b0;
        end else if (halts) begin
            for (int i = 0; i < 3; i++) push('0, {tag, "/halted"}, i);
            for (int i = 0; i < 3; i++) begin
                ir = $urandom;
                stop = 1'($urandom_range(0, 1));
                con_ff = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
            end
            stop = 1'b0;
            con_ff = 1'b0;
            push('0, {tag, "/reclear"}, 0);
            clear = 1'b1;
            @(posedge clock); #1;
            clear = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL ctl %s step %0d: got %h expected %h", e.tag, e.step, got, e.v);
            end
            checks++;
            if ($countones(got[27:20]) > 1) begin
                errors++;
                $display("FAIL bus_onehot %s step %0d: sources %b expected at most one", e.tag, e.step, got[27:20]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int clr;
        @(posedge clock); #1;
        push('0, "reset", 0);
        push('0, "reset", 1);
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;

        issue(32'h18908000, "add", 0, 0, -1);
        issue(32'h00800055, "ld", 0, 0, -1);
        issue(32'h98800010, "br_c0", 0, 0, -1);
        issue(32'h98800010, "br_c1", 1, 0, -1);
        issue(32'h98800010, "br_rnd", 2, 0, -1);
        issue(32'h81800000, "mul", 0, 0, -1);
        issue(32'h10800004, "st", 0, 0, -1);
        issue(32'hD0000000, "nop", 0, 0, -1);
        issue(32'hD8000000, "halt", 0, 0, -1);
        issue(32'h18908000, "add_stop", 0, 1, -1);
        issue(32'h00800055, "ld_clear", 0, 0, 5);
        issue(32'hA1000000, "jal", 0, 0, -1);

        for (int k = 0; k < 250; k++) begin
            ins = $urandom;
            clr = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 7)) : -1;
            issue(ins, $sformatf("rnd%0d_op%0d", k, ins[31:27]), 2, 2, clr);
        end

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
